// File: rtl/pool_out_writer.sv
// Captures pooled pixels into a small show-ahead FIFO and writes them to the
// output feature-map SRAM in raster order, absorbing memory back-pressure.
module pool_out_writer #(
  parameter int DATA_W     = 16,
  parameter int OUT_W      = 14,
  parameter int OUT_H      = 14,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 8,
  parameter int BASE_ADDR  = 0
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic                          start,
  input  logic                          pool_valid,
  input  logic [DATA_W-1:0]             pool_data,
  output logic                          mem_wr_en,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wr_data,
  input  logic                          mem_ready,
  output logic                          busy,
  output logic                          frame_done,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int TOTAL = OUT_W * OUT_H;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic [DATA_W-1:0]   r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_rdPtr;
  logic [PTR_W-1:0]    r_wrPtr;
  logic [LVL_W-1:0]    r_level;
  logic [CNT_W-1:0]    r_rxCount;
  logic [CNT_W-1:0]    r_wrCount;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_overflow;

  logic w_busy;
  logic w_full;
  logic w_wrEn;
  logic w_pop;
  logic w_push;
  logic w_drop;
  logic w_startFrame;
  logic w_lastRx;
  logic w_lastWr;

  // Write request depends only on registered state, never on mem_ready.
  assign w_busy       = (r_state == COLLECT) || (r_state == DRAIN);
  assign w_full       = (r_level == LVL_W'(FIFO_DEPTH));
  assign w_wrEn       = w_busy && (r_level != '0);
  assign w_pop        = w_wrEn && mem_ready;
  assign w_push       = (r_state == COLLECT) && pool_valid && (!w_full || w_pop);
  assign w_drop       = pool_valid &&
                        (((r_state == COLLECT) && w_full && !w_pop) || (r_state == DRAIN));
  assign w_startFrame = (r_state == IDLE) && start;
  assign w_lastRx     = w_push && (r_rxCount == CNT_W'(TOTAL - 1));
  assign w_lastWr     = w_pop && (r_wrCount == CNT_W'(TOTAL - 1));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    busy        = 1'b0;
    frame_done  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_nextState = COLLECT;
      end
      COLLECT: begin
        busy = 1'b1;
        if (w_lastRx) w_nextState = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (w_lastWr) w_nextState = DONE;
      end
      DONE: begin
        frame_done  = 1'b1;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_fifo[i] <= '0;
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wrPtr] <= pool_data;
        r_wrPtr         <= r_wrPtr + 1'b1;
      end
      if (w_pop) r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Counters saturate at the frame size; the address runs alongside wr_count.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_rxCount  <= '0;
      r_wrCount  <= '0;
      r_addr     <= ADDR_W'(BASE_ADDR);
      r_overflow <= 1'b0;
    end else if (w_startFrame) begin
      r_rxCount  <= '0;
      r_wrCount  <= '0;
      r_addr     <= ADDR_W'(BASE_ADDR);
      r_overflow <= 1'b0;
    end else begin
      if (w_push && (r_rxCount != CNT_W'(TOTAL))) r_rxCount <= r_rxCount + 1'b1;
      if (w_pop && (r_wrCount != CNT_W'(TOTAL))) begin
        r_wrCount <= r_wrCount + 1'b1;
        r_addr    <= r_addr + 1'b1;
      end
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  assign mem_wr_en   = w_wrEn;
  assign mem_addr    = r_addr;
  assign mem_wr_data = r_fifo[r_rdPtr];
  assign overflow    = r_overflow;
  assign fifo_level  = r_level;

endmodule

// File: tb/tb_pool_out_writer.sv
// Randomized scoreboard bench for pool_out_writer; two instances (base 0 and
// base 50) share stimulus and are checked against a frame-level model.
module tb_pool_out_writer;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 4;
  localparam int TOTAL  = 196;
  localparam int BASE_B = 50;

  logic              clk = 1'b0;
  logic              nrst = 1'b1;
  logic              start = 1'b0;
  logic              pool_valid = 1'b0;
  logic [DATA_W-1:0] pool_data = '0;
  logic              mem_ready = 1'b0;

  logic              wrEnA, busyA, doneA, ovfA;
  logic [ADDR_W-1:0] addrA;
  logic [DATA_W-1:0] dataA;
  logic [2:0]        levelA;
  logic              wrEnB, busyB, doneB, ovfB;
  logic [ADDR_W-1:0] addrB;
  logic [DATA_W-1:0] dataB;
  logic [2:0]        levelB;

  pool_out_writer #(.BASE_ADDR(0)) u_dutA (
    .clk(clk), .nrst(nrst), .start(start), .pool_valid(pool_valid),
    .pool_data(pool_data), .mem_wr_en(wrEnA), .mem_addr(addrA),
    .mem_wr_data(dataA), .mem_ready(mem_ready), .busy(busyA),
    .frame_done(doneA), .overflow(ovfA), .fifo_level(levelA)
  );

  pool_out_writer #(.BASE_ADDR(BASE_B)) u_dutB (
    .clk(clk), .nrst(nrst), .start(start), .pool_valid(pool_valid),
    .pool_data(pool_data), .mem_wr_en(wrEnB), .mem_addr(addrB),
    .mem_wr_data(dataB), .mem_ready(mem_ready), .busy(busyB),
    .frame_done(doneB), .overflow(ovfB), .fifo_level(levelB)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [15:0] data;
  } exp_t;

  // Frame-level model: 0 idle, 1 collecting, 2 draining, 3 done pulse.
  int   mState = 0;
  int   mLevel = 0;
  int   mRx = 0;
  int   mWr = 0;
  bit   mOvf = 1'b0;
  exp_t sb[$];

  int errors = 0;
  int checks = 0;
  int doneCount = 0;
  int maxLevel = 0;
  bit checking = 1'b0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic void modelReset();
    mState = 0;
    mLevel = 0;
    mRx    = 0;
    mWr    = 0;
    mOvf   = 1'b0;
    sb.delete();
  endfunction

  // Advances the model across one clock edge using the inputs presented before it.
  function automatic void modelEdge();
    int st;
    bit pop;
    st  = mState;
    pop = ((st == 1) || (st == 2)) && (mLevel > 0) && mem_ready;
    case (st)
      0: if (start) begin
        mState = 1; mRx = 0; mWr = 0; mOvf = 1'b0;
      end
      1: if (pool_valid) begin
        if ((mLevel < DEPTH) || pop) begin
          sb.push_back('{mRx, pool_data});
          mRx++;
          mLevel++;
          if (mRx == TOTAL) mState = 2;
        end else begin
          mOvf = 1'b1;
        end
      end
      2: if (pool_valid) mOvf = 1'b1;
      default: mState = 0;
    endcase
    if (pop) begin
      mLevel--;
      mWr++;
      if (mWr == TOTAL) mState = 3;
    end
  endfunction

  task automatic applyStimulus(input bit st, input bit pv, input logic [15:0] pd, input bit rdy);
    start      = st;
    pool_valid = pv;
    pool_data  = pd;
    mem_ready  = rdy;
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic checkDut(input string tag, input int base, input logic wrEn,
                          input logic [ADDR_W-1:0] addr, input logic busyO,
                          input logic doneO, input logic ovfO, input logic [2:0] lvl);
    bit eb;
    eb = (mState == 1) || (mState == 2);
    checkOutput({tag, "_busy"}, int'(busyO), int'(eb));
    checkOutput({tag, "_wr_en"}, int'(wrEn), int'(eb && (mLevel > 0)));
    checkOutput({tag, "_frame_done"}, int'(doneO), int'(mState == 3));
    checkOutput({tag, "_overflow"}, int'(ovfO), int'(mOvf));
    checkOutput({tag, "_level"}, int'(lvl), mLevel);
    checkOutput({tag, "_addr"}, int'(addr), base + mWr);
  endtask

  // Monitor: per-cycle status checks plus scoreboard pop on every accepted write.
  always @(negedge clk) begin
    exp_t e;
    if (checking) begin
      checkDut("A", 0, wrEnA, addrA, busyA, doneA, ovfA, levelA);
      checkDut("B", BASE_B, wrEnB, addrB, busyB, doneB, ovfB, levelB);
      if (int'(levelA) > maxLevel) maxLevel = int'(levelA);
      if (doneA) doneCount++;
      if (wrEnA && mem_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL sb_empty: got write addr=%0d data=%0d expected no write", addrA, dataA);
        end else begin
          e = sb.pop_front();
          checkOutput("A_wr_data", int'(dataA), int'(e.data));
          checkOutput("A_wr_addr", int'(addrA), e.idx);
          checkOutput("B_wr_data", int'(dataB), int'(e.data));
          checkOutput("B_wr_addr", int'(addrB), e.idx + BASE_B);
        end
      end
    end
  end

  task automatic waitIdle(input int budget);
    int n;
    n = 0;
    while ((mState != 0) && (n < budget)) begin
      applyStimulus(mState == 3, 1'b0, '0, 1'b1);
      n++;
    end
    checkOutput("frame_finish_in_budget", int'(mState == 0), 1);
  endtask

  task automatic feedRandom(input int budget);
    int n;
    n = 0;
    while ((mState == 1) && (n < budget)) begin
      applyStimulus(($urandom % 40) == 0, $urandom % 2, 16'($urandom), $urandom % 3 != 0);
      n++;
    end
  endtask

  initial begin
    int n;
    int doneBefore;

    #2 nrst = 1'b0;
    modelReset();
    checking = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 nrst = 1'b1;
    checkOutput("reset_addrB", int'(addrB), BASE_B);

    // Nominal frame, with an ignored start mid-frame.
    doneBefore = doneCount;
    applyStimulus(1'b1, 1'b0, '0, 1'b1);
    for (int i = 0; i < TOTAL; i++) begin
      applyStimulus(1'b0, 1'b1, 16'(i), 1'b1);
      applyStimulus(i == 60, 1'b0, '0, 1'b1);
    end
    waitIdle(50);
    checkOutput("nominal_done_once", doneCount - doneBefore, 1);

    // Back-pressure: ready one cycle in four, a sample every four cycles.
    maxLevel = 0;
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    n = 0;
    while ((mState == 1) && (n < 2000)) begin
      applyStimulus(1'b0, (n % 4) == 0, 16'($urandom), (n % 4) == 3);
      n++;
    end
    waitIdle(100);
    checkOutput("bp_max_level_le_depth", int'(maxLevel <= DEPTH), 1);

    // Overflow: five back-to-back samples into a stalled memory.
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 16'(i), 1'b0);
    checkOutput("ovf_level_full", int'(levelA), DEPTH);
    checkOutput("ovf_flag_set", int'(ovfA), 1);
    feedRandom(3000);
    waitIdle(100);
    checkOutput("ovf_sticky_after_frame", int'(ovfA), 1);

    // Full FIFO with simultaneous push and pop.
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 16'(100 + i), 1'b0);
    applyStimulus(1'b0, 1'b1, 16'(104), 1'b1);
    checkOutput("fullpp_level", int'(levelA), DEPTH);
    checkOutput("fullpp_overflow", int'(ovfA), 0);
    feedRandom(3000);
    waitIdle(100);

    // Fully random frame.
    applyStimulus(1'b1, 1'b0, '0, 1'b1);
    feedRandom(3000);
    waitIdle(100);

    // Reset mid-frame after 100 writes, then a clean frame.
    applyStimulus(1'b1, 1'b0, '0, 1'b1);
    n = 0;
    while ((mWr < 100) && (n < 2000)) begin
      applyStimulus(1'b0, 1'b1, 16'($urandom), $urandom % 2);
      n++;
    end
    checkOutput("midreset_reached_100", int'(mWr >= 100), 1);
    doneBefore = doneCount;
    nrst = 1'b0;
    modelReset();
    #1;
    checkOutput("midreset_busy_clear", int'(busyA), 0);
    checkOutput("midreset_level_clear", int'(levelA), 0);
    @(posedge clk);
    @(posedge clk);
    #1 nrst = 1'b1;
    checkOutput("midreset_no_done", doneCount - doneBefore, 0);
    applyStimulus(1'b1, 1'b0, '0, 1'b1);
    feedRandom(3000);
    waitIdle(100);

    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    checkOutput("total_frames_done", doneCount, 6);
    checkOutput("scoreboard_drained", sb.size(), 0);
    checking = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pool_out_writer.md
Name: pool_out_writer

Overview:
- Downstream consumer of the 2x2 max-pooling stage.
- Captures each pooled pixel, strobed by the pooling stage's pool_done, into a small elastic FIFO, then writes it to the output feature-map SRAM in raster order.
- The pooling stage cannot stall, so this block absorbs memory back-pressure and flags any lost samples.
- Signals frame completion to the layer sequencer.

Parameters:
- DATA_W, 16, width of a pooled pixel.
- OUT_W, 14, pooled feature-map width (input width 28 >> 1).
- OUT_H, 14, pooled feature-map height.
- FIFO_DEPTH, 4, elastic buffer entries; must be a power of two, at least 2.
- ADDR_W, 8, SRAM address width; must satisfy 2^ADDR_W >= BASE_ADDR + OUT_W*OUT_H.
- BASE_ADDR, 0, SRAM address of pixel (0,0).

Ports:
- clk, input, 1, clock.
- nrst, input, 1, reset: asynchronous, active-low.
- start, input, 1, single-cycle frame start; same cycle as the pooling stage's start.
- pool_valid, input, 1, pooled pixel strobe (the pooling stage's pool_done).
- pool_data, input, DATA_W, pooled pixel; valid when pool_valid=1.
- mem_wr_en, output, 1, SRAM write request.
- mem_addr, output, ADDR_W, SRAM write address.
- mem_wr_data, output, DATA_W, SRAM write data.
- mem_ready, input, 1, SRAM accepts a write this cycle; a write occurs when mem_wr_en && mem_ready.
- busy, output, 1, high in COLLECT or DRAIN.
- frame_done, output, 1, one-cycle pulse after the last SRAM write of the frame is accepted.
- overflow, output, 1, sticky lost-sample flag; cleared by start or reset.
- fifo_level, output, $clog2(FIFO_DEPTH)+1, current FIFO occupancy.

Behaviour:
- Reset (nrst=0, async): state IDLE; FIFO empty; rx_count=0, wr_count=0, mem_addr=BASE_ADDR. All outputs 0 except mem_addr=BASE_ADDR. Reset mid-frame abandons the frame; no frame_done is issued.
- States: IDLE, COLLECT, DRAIN, DONE.
- IDLE:
  - pool_valid is ignored.
  - start -> COLLECT; clears rx_count, wr_count and overflow; loads mem_addr=BASE_ADDR.
- COLLECT:
  - pool_valid pushes pool_data into the FIFO; rx_count increments on every accepted push.
  - When rx_count reaches OUT_W*OUT_H (196 at defaults) -> DRAIN.
- DRAIN:
  - No pushes.
  - pool_valid sets overflow; the sample is dropped.
  - When wr_count reaches OUT_W*OUT_H -> DONE.
- DONE: one cycle; frame_done=1; -> IDLE.
- start while busy is ignored; it does not restart the frame.
- FIFO:
  - Show-ahead: mem_wr_data is always the head entry.
  - mem_wr_en = busy && (fifo_level != 0); it is combinational from registered state only and has no path from mem_ready.
  - Pop on mem_wr_en && mem_ready.
- Push/pop corner cases:
  - Full with no pop: a push is rejected, overflow=1, rx_count does not increment.
  - Full with a pop in the same cycle: the push is accepted and the level stays at FIFO_DEPTH.
  - Empty with a push: mem_wr_en asserts the next cycle. Latency from pool_valid to first mem_wr_en is 1 cycle; there is no same-cycle bypass.
- Addressing:
  - mem_addr = BASE_ADDR + wr_count, maintained as a running register incremented on each accepted write.
  - No multiplier. The raster row/column wrap is implicit in the linear address.
  - mem_addr holds its value while mem_ready=0.
- Counter sizing:
  - rx_count and wr_count are $clog2(OUT_W*OUT_H+1) bits wide.
  - They saturate at OUT_W*OUT_H and never wrap within a frame.
- Frame completion:
  - frame_done fires exactly once per frame, in the cycle after the 196th accepted write. busy is low in that cycle.
  - A start asserted during DONE is ignored.
- Overflow:
  - Overflow samples do not advance rx_count. With drops, the frame therefore stays in COLLECT until 196 samples have actually been stored.
  - The sequencer uses overflow to abort the layer.

Test Plan:
- Nominal frame: reset, start, 196 pool_valid pulses every 2 cycles with data=index, mem_ready=1 -> 196 writes at addresses 0..195 with data 0..195, no overflow, frame_done exactly once, 1 cycle after write 195.
- Back-pressure: mem_ready low 3 of every 4 cycles, pool_valid every 4 cycles -> fifo_level never exceeds 4, all 196 data in order, overflow=0.
- Overflow: mem_ready=0, 5 back-to-back pool_valid -> first 4 stored (fifo_level=4), 5th dropped, overflow=1; release mem_ready -> data 0..3 written at addresses 0..3.
- Full push+pop: FIFO full, pool_valid and mem_ready high in the same cycle -> push accepted, fifo_level stays 4, overflow stays 0.
- BASE_ADDR=50: full frame -> addresses 50..245; start pulsed mid-frame is ignored, with no address restart.
- Reset mid-frame: nrst low after 100 writes -> all outputs cleared immediately, no frame_done; a new start gives a clean frame beginning at address BASE_ADDR.
